conv_bf16tomxi8_sched: RTL and testbench

// Shares one conv_bf16tomxi8 converter between N_REQ bf16 vector requesters.
// - Round-robin arbitration; the granted vector goes to the converter input register.
// - A tag travels alongside each vector through the converter's fixed latency.
// - Results are captured into a credit-protected output FIFO, so downstream may stall;
//   the converter itself never stalls.
// - A flush sequence stops new grants and drains all in-flight blocks.

---
 rtl/conv_bf16tomxi8_sched.sv | 178 +++++++++++++++++
 tb/tb_conv_bf16tomxi8_sched.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_bf16tomxi8_sched.sv
// Round-robin scheduler sharing one bf16->MX converter between N_REQ requesters, with a tag
// pipe, credit-protected output FIFO and flush/drain. Optional CONV_SCHED_STATS_EN adds counters.
module conv_bf16tomxi8_sched #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned k         = 32,
    parameter int unsigned bit_width = 8,
    parameter int unsigned CONV_LAT  = 2,
    parameter int unsigned OUT_DEPTH = 4,
    localparam int unsigned TW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [N_REQ-1:0]              i_req_valid,
    output logic [N_REQ-1:0]              o_req_ready,
    input  logic [N_REQ-1:0][k-1:0][15:0] i_req_vec,
    output logic [k-1:0][15:0]            o_conv_vec,
    input  logic [k-1:0][bit_width-1:0]   i_conv_mx_vec,
    input  logic [7:0]                    i_conv_mx_exp,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [k-1:0][bit_width-1:0]   o_mx_vec,
    output logic [7:0]                    o_mx_exp,
    output logic [TW-1:0]                 o_tag,
    input  logic                          i_flush,
`ifdef CONV_SCHED_STATS_EN
    output logic [N_REQ-1:0][15:0]        o_issue_cnt,
`endif
    output logic                          o_flush_done
);

    localparam int unsigned PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CW = $clog2(OUT_DEPTH + 1);

    typedef enum logic [1:0] {StRun, StDrain, StDone, StHold} state_e;

    state_e                      state_q, state_d;
    logic [TW-1:0]               rr_q, rr_d;
    logic [CW-1:0]               inflight_q, inflight_d;
    logic [CW-1:0]               fifo_cnt_q, fifo_cnt_d;
    logic [CW:0]                 credit_sum;
    logic                        space, gnt_en, gnt_any, issue, capture, pop;
    logic                        hi_any, lo_any;
    logic [TW-1:0]               hi_idx, lo_idx, gnt_idx, cap_tag;
    logic [CONV_LAT:0]           vpipe_q;
    logic [CONV_LAT:0][TW-1:0]   tpipe_q;
    logic [k-1:0][15:0]          conv_vec_q;
    logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [k-1:0][bit_width-1:0] mem_vec_q [OUT_DEPTH];
    logic [7:0]                  mem_exp_q [OUT_DEPTH];
    logic [TW-1:0]               mem_tag_q [OUT_DEPTH];

    // Lowest valid index at/after rr_q wins; otherwise lowest valid index below rr_q.
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (i_req_valid[i]) begin
                if (i >= int'(rr_q)) begin
                    hi_any = 1'b1;
                    hi_idx = TW'(i);
                end else begin
                    lo_any = 1'b1;
                    lo_idx = TW'(i);
                end
            end
        end
        gnt_any = hi_any | lo_any;
        gnt_idx = hi_any ? hi_idx : lo_idx;
    end

    // Credit counts blocks issued but not yet popped, so the FIFO can never overflow.
    assign credit_sum  = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    assign space       = credit_sum < (CW+1)'(OUT_DEPTH);
    assign issue       = gnt_en & gnt_any;
    assign o_req_ready = issue ? (N_REQ'(1) << gnt_idx) : '0;
    assign rr_d        = (gnt_idx == TW'(N_REQ - 1)) ? '0 : gnt_idx + TW'(1);

    assign capture    = vpipe_q[CONV_LAT];
    assign cap_tag    = tpipe_q[CONV_LAT];
    assign o_valid    = (fifo_cnt_q != '0) & i_rst_n;
    assign pop        = o_valid & i_ready;
    assign inflight_d = inflight_q + CW'(issue) - CW'(capture);
    assign fifo_cnt_d = fifo_cnt_q + CW'(capture) - CW'(pop);

    always_comb begin
        state_d      = state_q;
        gnt_en       = 1'b0;
        o_flush_done = 1'b0;
        case (state_q)
            StRun: begin
                gnt_en = ~i_flush & space & i_rst_n;
                if (i_flush) state_d = StDrain;
            end
            StDrain: begin
                if (inflight_q == '0 && fifo_cnt_q == '0) state_d = StDone;
            end
            StDone: begin
                o_flush_done = 1'b1;
                state_d      = i_flush ? StHold : StRun;
            end
            StHold: begin
                if (!i_flush) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= StRun;
            rr_q       <= '0;
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            vpipe_q    <= '0;
            tpipe_q    <= '0;
            conv_vec_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            vpipe_q[0] <= issue;
            tpipe_q[0] <= gnt_idx;
            for (int s = 1; s <= int'(CONV_LAT); s++) begin
                vpipe_q[s] <= vpipe_q[s-1];
                tpipe_q[s] <= tpipe_q[s-1];
            end
            if (issue) begin
                rr_q       <= rr_d;
                conv_vec_q <= i_req_vec[gnt_idx];
            end
            if (capture) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (capture && i_rst_n) begin
            mem_vec_q[wr_ptr_q] <= i_conv_mx_vec;
            mem_exp_q[wr_ptr_q] <= i_conv_mx_exp;
        end
    end

    // Tags are reset so o_tag reads 0 while the FIFO is empty after reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int e = 0; e < int'(OUT_DEPTH); e++) mem_tag_q[e] <= '0;
        end else if (capture) begin
            mem_tag_q[wr_ptr_q] <= cap_tag;
        end
    end

    assign o_conv_vec = conv_vec_q;
    assign o_mx_vec   = mem_vec_q[rd_ptr_q];
    assign o_mx_exp   = mem_exp_q[rd_ptr_q];
    assign o_tag      = mem_tag_q[rd_ptr_q];

`ifdef CONV_SCHED_STATS_EN
    logic [N_REQ-1:0][15:0] issue_cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            issue_cnt_q <= '0;
        end else if (issue && issue_cnt_q[gnt_idx] != 16'hFFFF) begin
            issue_cnt_q[gnt_idx] <= issue_cnt_q[gnt_idx] + 16'd1;
        end
    end

    assign o_issue_cnt = issue_cnt_q;
`endif

    fifo_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(capture && fifo_cnt_q == CW'(OUT_DEPTH)));

endmodule

// File: tb/tb_conv_bf16tomxi8_sched.sv
// Randomized scoreboard bench for conv_bf16tomxi8_sched with a behavioural converter stand-in.
`timescale 1ns/1ps
module tb_conv_bf16tomxi8_sched;

    localparam int unsigned N_REQ     = 2;
    localparam int unsigned K         = 32;
    localparam int unsigned BW        = 8;
    localparam int unsigned CONV_LAT  = 2;
    localparam int unsigned OUT_DEPTH = 4;
    localparam int unsigned TW        = 1;

    typedef logic [K-1:0][15:0] bvec_t;
    typedef logic [K-1:0][BW-1:0] mvec_t;
    typedef struct packed {
        mvec_t         m;
        logic [7:0]    e;
        logic [TW-1:0] t;
    } exp_t;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ-1:0]              req_ready;
    logic [N_REQ-1:0][K-1:0][15:0] req_vec;
    bvec_t                         conv_vec;
    mvec_t                         conv_mx;
    logic [7:0]                    conv_exp;
    logic                          out_valid;
    logic                          out_ready;
    mvec_t                         mx_vec;
    logic [7:0]                    mx_exp;
    logic [TW-1:0]                 tag;
    logic                          flush;
    logic                          flush_done;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    int   n_iss = 0;
    int   n_pop = 0;
    int   rr_m = 0;
    int   cyc = 0;
    int   hs_cyc = 0;
    bit   chk_grant = 1'b0;

    conv_bf16tomxi8_sched #(
        .N_REQ(N_REQ), .k(K), .bit_width(BW), .CONV_LAT(CONV_LAT), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_vec    (req_vec),
        .o_conv_vec   (conv_vec),
        .i_conv_mx_vec(conv_mx),
        .i_conv_mx_exp(conv_exp),
        .o_valid      (out_valid),
        .i_ready      (out_ready),
        .o_mx_vec     (mx_vec),
        .o_mx_exp     (mx_exp),
        .o_tag        (tag),
        .i_flush      (flush),
        .o_flush_done (flush_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference conversion: shared exponent = max bf16 exponent, element = sign + aligned mantissa.
    function automatic logic [7:0] emax_of(input bvec_t v);
        int mx;
        mx = 0;
        for (int j = 0; j < int'(K); j++) if (int'(v[j][14:7]) > mx) mx = int'(v[j][14:7]);
        return 8'(mx);
    endfunction

    function automatic mvec_t mx_of(input bvec_t v);
        mvec_t m;
        int    em, e, sh, mag;
        em = int'(emax_of(v));
        for (int j = 0; j < int'(K); j++) begin
            e  = int'(v[j][14:7]);
            sh = em - e;
            if (e == 0 || sh > 7) mag = 0;
            else mag = (64 + int'(v[j][6:1])) >> sh;
            m[j] = {v[j][15], 7'(mag)};
        end
        return m;
    endfunction

    function automatic bvec_t rand_vec();
        bvec_t v;
        for (int j = 0; j < int'(K); j++)
            v[j] = {1'($urandom), 8'(120 + $urandom_range(0, 7)), 7'($urandom)};
        return v;
    endfunction

    function automatic logic [N_REQ-1:0] exp_grant(input logic [N_REQ-1:0] v, input int rr,
                                                   input bit has_space);
        logic [N_REQ-1:0] g;
        bit               found;
        int               r;
        g     = '0;
        found = 1'b0;
        if (has_space) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                r = (rr + i) % int'(N_REQ);
                if (!found && v[r]) begin
                    g[r]  = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return g;
    endfunction

    // Converter stand-in: samples o_conv_vec each edge, result appears CONV_LAT edges later.
    bvec_t dl [CONV_LAT];
    always @(posedge clk) begin
        dl[0] <= conv_vec;
        for (int i = 1; i < int'(CONV_LAT); i++) dl[i] <= dl[i-1];
    end
    assign conv_mx  = mx_of(dl[CONV_LAT-1]);
    assign conv_exp = emax_of(dl[CONV_LAT-1]);

    always @(negedge clk) begin
        logic [N_REQ-1:0] eg;
        exp_t             x;
        if (!rst_n) begin
            checks += 2;
            if (req_ready !== '0) begin
                errors++;
                $display("FAIL reset_ready: got %b want 0", req_ready);
            end
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid: got %b want 0", out_valid);
            end
            sb_q.delete();
            n_iss = 0;
            n_pop = 0;
            rr_m  = 0;
        end else begin
            if (chk_grant) begin
                eg = exp_grant(req_valid, rr_m, (n_iss - n_pop) < int'(OUT_DEPTH));
                checks++;
                if (req_ready !== eg) begin
                    errors++;
                    $display("FAIL grant: got %b want %b (t=%0t)", req_ready, eg, $time);
                end
            end
            for (int r = 0; r < int'(N_REQ); r++) begin
                if (req_valid[r] && req_ready[r]) begin
                    sb_q.push_back({mx_of(req_vec[r]), emax_of(req_vec[r]), TW'(r)});
                    n_iss++;
                    rr_m = (r + 1) % int'(N_REQ);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL output_unexpected: got tag %0d exp %0h, want no output", tag,
                             mx_exp);
                end else begin
                    x = sb_q.pop_front();
                    if ({mx_vec, mx_exp, tag} !== x) begin
                        errors++;
                        $display("FAIL output_data: got %h/%h/%0d want %h/%h/%0d", mx_vec,
                                 mx_exp, tag, x.m, x.e, x.t);
                    end
                end
                n_pop++;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic step(output logic [N_REQ-1:0] hs);
        @(negedge clk);
        hs     = req_valid & req_ready;
        hs_cyc = cyc;
        @(posedge clk);
        #1;
        for (int r = 0; r < int'(N_REQ); r++) if (hs[r]) req_vec[r] = rand_vec();
    endtask

    task automatic idle(input int n);
        logic [N_REQ-1:0] hs;
        repeat (n) step(hs);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N_REQ-1:0] hs;
        int               cnt, lat, pulses, pops0, prev, cur;
        bit               seen;

        req_valid = '1;
        for (int r = 0; r < int'(N_REQ); r++) req_vec[r] = rand_vec();
        out_ready = 1'b1;
        flush     = 1'b0;

        // Reset with all requesters valid
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_conv_vec_zero", 64'(conv_vec != '0), 0);
        check("reset_tag", 64'(tag), 0);
        check("reset_flush_done", 64'(flush_done), 0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;
        chk_grant = 1'b1;
        idle(2);

        // Single block of 1.0 values
        req_vec[0] = {K{16'h3F80}};
        req_valid  = 2'b01;
        seen       = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(hs);
            if (hs[0]) seen = 1'b1;
        end
        req_valid = '0;
        check("single_handshake", 64'(seen), 1);
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - hs_cyc;
                check("single_tag", 64'(tag), 0);
                check("single_exp", 64'(mx_exp), 64'h7F);
                check("single_elem0", 64'(mx_vec[0]), 64'h40);
                break;
            end
        end
        check("single_latency", 64'(lat), 64'(CONV_LAT + 2));
        @(posedge clk);
        #1;
        idle(4);

        // Fairness with both requesters continuously valid
        req_valid = '1;
        prev      = -1;
        cnt       = 0;
        for (int i = 0; i < 40; i++) begin
            step(hs);
            if (hs != '0) begin
                check("fair_onehot", 64'($countones(hs)), 1);
                cur = hs[1] ? 1 : 0;
                if (prev >= 0) check("fair_alternate", 64'(cur), 64'(1 - prev));
                prev = cur;
                cnt++;
            end
        end
        req_valid = '0;
        check("fair_throughput", 64'(cnt >= 20), 1);
        idle(8);

        // Backpressure: credit limits handshakes to OUT_DEPTH
        out_ready = 1'b0;
        req_valid = 2'b01;
        cnt       = 0;
        for (int i = 0; i < 20; i++) begin
            step(hs);
            cnt += $countones(hs);
        end
        check("bp_handshakes", 64'(cnt), 64'(OUT_DEPTH));
        out_ready = 1'b1;
        step(hs);
        cnt       = $countones(hs);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(hs);
            cnt += $countones(hs);
        end
        check("bp_one_more", 64'(cnt), 1);
        @(negedge clk);
        check("bp_ready_low", 64'(req_ready), 0);
        @(posedge clk);
        #1;
        req_valid = '0;
        out_ready = 1'b1;
        idle(10);

        // Flush after three issued blocks
        req_valid = '1;
        cnt       = 0;
        for (int i = 0; i < 10 && cnt < 3; i++) begin
            step(hs);
            cnt += $countones(hs);
        end
        check("flush_issued", 64'(cnt), 3);
        chk_grant = 1'b0;
        flush     = 1'b1;
        pops0     = n_pop;
        pulses    = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("flush_no_grant", 64'(req_ready), 0);
            if (flush_done) begin
                pulses++;
                check("flush_outputs_before_done", 64'(n_pop - pops0), 3);
                check("flush_sb_empty", 64'(sb_q.size()), 0);
            end
        end
        check("flush_pulses", 64'(pulses), 1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            step(hs);
            if (hs != '0) seen = 1'b1;
        end
        check("flush_resume", 64'(seen), 1);
        req_valid = '0;
        chk_grant = 1'b1;
        idle(10);

        // Reset with two blocks in flight
        req_valid = 2'b01;
        cnt       = 0;
        for (int i = 0; i < 10 && cnt < 2; i++) begin
            step(hs);
            cnt += $countones(hs);
        end
        req_valid = '0;
        chk_grant = 1'b0;
        rst_n     = 1'b0;
        step(hs);
        rst_n     = 1'b1;
        chk_grant = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_no_stale_valid", 64'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        seen      = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(hs);
            if (hs[1]) seen = 1'b1;
        end
        req_valid = '0;
        check("rst_next_handshake", 64'(seen), 1);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                check("rst_next_tag", 64'(tag), 1);
            end
        end
        check("rst_next_result", 64'(seen), 1);
        @(posedge clk);
        #1;
        idle(10);
        check("final_sb_empty", 64'(sb_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
